// File: rtl/key_event_fsm_pkg.sv
// ---------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key gesture classifier:
//   state_t        - 3-bit FSM state encoding (IDLE/PRESS1/WAIT2/PRESS2/HOLD)
//   *_DEF          - default timing constants for a 50 MHz system clock
// ---------------------------------------------------------------------------
package key_evt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // key released, no gesture in progress
    PRESS1 = 3'd1,  // first press in progress
    WAIT2  = 3'd2,  // released after first click, waiting for a second press
    PRESS2 = 3'd3,  // second press of a possible double click
    HOLD   = 3'd4   // long press reported, waiting for release
  } state_t;

  localparam int          CNT_W_DEF    = 26;
  localparam int unsigned LONG_CYC_DEF = 50_000_000;  // 1 s at 50 MHz
  localparam int unsigned DCLK_CYC_DEF = 12_500_000;  // 250 ms at 50 MHz

endpackage

// File: rtl/key_event_fsm_if.sv
// ---------------------------------------------------------------------------
// key_event_fsm_if
// Groups the debounced key level with the gesture event outputs.
//   key_db    debounced key level, 0 = pressed, idle 1
//   short_o   one-cycle pulse: single short click completed
//   long_o    one-cycle pulse: press held long enough
//   double_o  one-cycle pulse: second click of a double click released
//   busy_o    classifier is mid-gesture
// Modports:
//   master - drives the key level and consumes the events (debouncer/LED side)
//   slave  - the classifier itself
// ---------------------------------------------------------------------------
interface key_event_fsm_if;

  logic key_db;
  logic short_o;
  logic long_o;
  logic double_o;
  logic busy_o;

  modport master (
    output key_db,
    input  short_o,
    input  long_o,
    input  double_o,
    input  busy_o
  );

  modport slave (
    input  key_db,
    output short_o,
    output long_o,
    output double_o,
    output busy_o
  );

endinterface

// File: rtl/key_event_fsm_edge_det.sv
// ---------------------------------------------------------------------------
// key_edge_det
// Registers each key level once and flags its falling/rising edges against
// the live input. The register resets to 1 (released), so a key already held
// low when reset is released is reported as a fresh press.
//   clk, rst_n   clock, asynchronous active-low reset
//   d            key levels (W bits, idle 1)
//   fall         d went 1 -> 0 this cycle
//   rise         d went 0 -> 1 this cycle
// ---------------------------------------------------------------------------
module key_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] fall,
  output logic [W-1:0] rise
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b1;
      else        d_q <= d[gi];
    end

    assign fall[gi] =  d_q & ~d[gi];
    assign rise[gi] = ~d_q &  d[gi];
  end

endmodule

// File: rtl/key_event_fsm.sv
// ---------------------------------------------------------------------------
// key_event_fsm
// Classifies debounced key gestures into short press, long press and double
// click, and emits one-cycle registered event pulses.
//   clk      system clock
//   rst_n    asynchronous reset, active-low
//   kif      key_event_fsm_if.slave: key_db in; short_o/long_o/double_o/busy_o out
// Parameters:
//   CNT_W     width of the shared duration counter
//   LONG_CYC  low cycles that qualify a long press
//   DCLK_CYC  max high gap between the clicks of a double click
// ---------------------------------------------------------------------------
module key_event_fsm
  import key_evt_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned LONG_CYC = LONG_CYC_DEF,
  parameter int unsigned DCLK_CYC = DCLK_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  key_event_fsm_if.slave   kif
);

  // Terminal counts: the counter reads N-1 during the Nth cycle of a state.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_TC = CNT_W'(DCLK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic fall;
  logic rise;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             short_q,  short_d;
  logic             long_q,   long_d;
  logic             double_q, double_d;
  logic             busy_q,   busy_d;

  key_edge_det #(.W(1)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kif.key_db),
    .fall  (fall),
    .rise  (rise)
  );

  // Next-state / event logic. Within each state the key edge is tested
  // before the terminal count so that an edge coinciding with the terminal
  // cycle takes precedence.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) state_d = PRESS1;
      end
      PRESS1: begin
        if (rise) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      WAIT2: begin
        if (fall) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLK_TC) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (rise) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == LONG_TC) begin
          // The pending first click is dropped; only the long press counts.
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  assign kif.short_o  = short_q;
  assign kif.long_o   = long_q;
  assign kif.double_o = double_q;
  assign kif.busy_o   = busy_q;

endmodule

// File: tb/tb_key_event_fsm.sv
// ---------------------------------------------------------------------------
// tb_key_event_fsm
// Drives key waveforms built from (level, length) runs, one waveform per
// segment, with a reset between segments. Expected outputs per cycle are
// derived from the run lengths (press/gap durations) of the waveform.
// ---------------------------------------------------------------------------
module tb_key_event_fsm;

  localparam int CNT_W = 6;
  localparam int LONG  = 20;
  localparam int DCLK  = 8;
  localparam int MAXN  = 1024;
  localparam int INF   = 1 << 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_event_fsm_if kif ();

  key_event_fsm #(
    .CNT_W    (CNT_W),
    .LONG_CYC (LONG),
    .DCLK_CYC (DCLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Waveform: kw[t] is the key level seen at clock edge t of the segment.
  bit kw  [MAXN];
  int n;
  // Expected outputs observed just after edge t.
  bit e_s [MAXN];
  bit e_l [MAXN];
  bit e_d [MAXN];
  bit e_b [MAXN];
  // Observed event counts of the last segment.
  int o_s, o_l, o_d;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic add_run(input bit lvl, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        kw[n] = lvl;
        n++;
      end
    end
  endtask

  // First edge index >= from where the key goes 1 -> 0 (level before edge 0 is 1).
  function automatic int next_fall(input int from);
    for (int i = from; i < n; i++) begin
      if (((i == 0) ? 1'b1 : kw[i-1]) == 1'b1 && kw[i] == 1'b0) return i;
    end
    return INF;
  endfunction

  function automatic int next_rise(input int from);
    for (int i = from; i < n; i++) begin
      if (i > 0 && kw[i-1] == 1'b0 && kw[i] == 1'b1) return i;
    end
    return INF;
  endfunction

  function automatic void mark_busy(input int a, input int b);
    for (int i = a; i <= b && i < n; i++) e_b[i] = 1'b1;
  endfunction

  // Gesture-level reference: walk presses and gaps by their durations.
  // A press is long when it stays low for more than LONG edges; a gap closes
  // a single click when it stays high for more than DCLK edges.
  function automatic void build_model();
    int t, tf, tr, tf2, tr2;
    for (int i = 0; i < MAXN; i++) begin
      e_s[i] = 0; e_l[i] = 0; e_d[i] = 0; e_b[i] = 0;
    end
    t = 0;
    while (t < n) begin
      tf = next_fall(t);
      if (tf >= n) break;
      tr = next_rise(tf + 1);
      if (tr - tf > LONG) begin
        if (tf + LONG < n) e_l[tf + LONG] = 1'b1;
        mark_busy(tf, tr - 1);
        t = (tr >= INF) ? INF : tr + 1;
        continue;
      end
      tf2 = next_fall(tr + 1);
      if (tf2 - tr > DCLK) begin
        if (tr + DCLK < n) e_s[tr + DCLK] = 1'b1;
        mark_busy(tf, tr + DCLK - 1);
        t = tf2;
        continue;
      end
      tr2 = next_rise(tf2 + 1);
      if (tr2 - tf2 > LONG) begin
        if (tf2 + LONG < n) e_l[tf2 + LONG] = 1'b1;
      end else begin
        if (tr2 < n) e_d[tr2] = 1'b1;
      end
      mark_busy(tf, tr2 - 1);
      t = (tr2 >= INF) ? INF : tr2 + 1;
    end
  endfunction

  // Called between clock edges; asserts reset asynchronously mid-cycle,
  // holds it for two cycles and releases it on a falling edge.
  task automatic do_reset(input int seg, input bit key_lvl);
    #2;
    rst_n = 1'b0;
    kif.key_db = key_lvl;
    #1;
    chk($sformatf("seg%0d rst short", seg),  kif.short_o,  1'b0);
    chk($sformatf("seg%0d rst long", seg),   kif.long_o,   1'b0);
    chk($sformatf("seg%0d rst double", seg), kif.double_o, 1'b0);
    chk($sformatf("seg%0d rst busy", seg),   kif.busy_o,   1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts and ends on a falling clock edge.
  task automatic run_seg(input int seg);
    build_model();
    o_s = 0; o_l = 0; o_d = 0;
    for (int t = 0; t < n; t++) begin
      kif.key_db = kw[t];
      @(posedge clk);
      #1;
      chk($sformatf("seg%0d t%0d short", seg, t),  kif.short_o,  e_s[t]);
      chk($sformatf("seg%0d t%0d long", seg, t),   kif.long_o,   e_l[t]);
      chk($sformatf("seg%0d t%0d double", seg, t), kif.double_o, e_d[t]);
      chk($sformatf("seg%0d t%0d busy", seg, t),   kif.busy_o,   e_b[t]);
      o_s += int'(kif.short_o === 1'b1);
      o_l += int'(kif.long_o === 1'b1);
      o_d += int'(kif.double_o === 1'b1);
      @(negedge clk);
    end
    $display("seg %0d: cycles=%0d short=%0d long=%0d double=%0d", seg, n, o_s, o_l, o_d);
  endtask

  task automatic chk_counts(input int seg, input int s, input int l, input int d);
    chk_int($sformatf("seg%0d short count", seg),  o_s, s);
    chk_int($sformatf("seg%0d long count", seg),   o_l, l);
    chk_int($sformatf("seg%0d double count", seg), o_d, d);
  endtask

  initial begin
    int seg;
    int r, len;
    bit lvl;
    kif.key_db = 1'b1;
    seg = 0;

    // 1. single click
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 5); add_run(1, 30);
    run_seg(seg); chk_counts(seg, 1, 0, 0); seg++;

    // 2. long press
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 30); add_run(1, 10);
    run_seg(seg); chk_counts(seg, 0, 1, 0); seg++;

    // 3. double click
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 3); add_run(1, 4); add_run(0, 3); add_run(1, 15);
    run_seg(seg); chk_counts(seg, 0, 0, 1); seg++;

    // 4a. second press exactly on the gap terminal cycle -> double
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 3); add_run(1, DCLK); add_run(0, 3); add_run(1, 15);
    run_seg(seg); chk_counts(seg, 0, 0, 1); seg++;

    // 4b. second press one cycle later -> short, then a new single click
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 3); add_run(1, DCLK + 1); add_run(0, 3); add_run(1, 15);
    run_seg(seg); chk_counts(seg, 2, 0, 0); seg++;

    // 5. release on the long terminal cycle -> short, no long
    do_reset(seg, 1'b1);
    n = 0; add_run(0, LONG); add_run(1, 15);
    run_seg(seg); chk_counts(seg, 1, 0, 0); seg++;

    // 6a. reset while in PRESS1
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 5);
    run_seg(seg); chk_counts(seg, 0, 0, 0); seg++;

    // 6b. reset while in WAIT2
    do_reset(seg, 1'b1);
    n = 0; add_run(0, 3); add_run(1, 4);
    run_seg(seg); chk_counts(seg, 0, 0, 0); seg++;

    // 6c. key held low across reset release -> long press
    do_reset(seg, 1'b0);
    n = 0; add_run(0, 25); add_run(1, 5);
    run_seg(seg); chk_counts(seg, 0, 1, 0); seg++;

    // Randomised gestures, biased toward the terminal-count boundaries.
    for (int k = 0; k < 10; k++) begin
      do_reset(seg, 1'($urandom_range(0, 1)));
      n = 0;
      lvl = 1'($urandom_range(0, 1));
      for (int j = 0; j < 24; j++) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       len = LONG;
          1:       len = LONG + 1;
          2:       len = DCLK;
          3:       len = DCLK + 1;
          4:       len = 1;
          default: len = $urandom_range(1, 30);
        endcase
        add_run(lvl, len);
        lvl = ~lvl;
      end
      if ($urandom_range(0, 1) == 1) add_run(1, 30);
      run_seg(seg);
      seg++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
